// File: rtl/mac_pkg.sv
// Shared types for the MAC tile sequencer: FSM states, tile descriptor, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mac_pkg;

   // Default geometry; the descriptor struct is sized from these.
   localparam int DEF_ARR    = 4;
   localparam int DEF_DIM_W  = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_TI_W   = DEF_DIM_W;
   localparam int DEF_SH_W   = $clog2(DEF_ARR*DEF_DATA_W+1);
   localparam int DEF_CW     = $clog2(DEF_ARR+1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, FIN} state_t;

   typedef struct packed {
      logic [DEF_TI_W-1:0]   m_idx;
      logic [DEF_TI_W-1:0]   n_idx;
      logic [DEF_TI_W-1:0]   t_idx;
      logic [DEF_SH_W-1:0]   sh_i;
      logic [DEF_SH_W-1:0]   sh_w;
      logic [DEF_CW-1:0]     row_act;
      logic [DEF_CW-1:0]     col_act;
      logic [2*DEF_TI_W-1:0] o_dst;
      logic                  acc;
   } tile_desc_t;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/mac_tile_ctrl_tile_counter.sv
// Three-level nested wrap counter (m outer, t middle, n inner) for tile indices.
// Latency: next-index outputs are combinational; indices update on the advancing edge.
// Backpressure: advances only when adv is high; clr has priority and zeroes all levels.
module tile_counter
   import mac_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         CLK,
   input  logic         RSTN,
   input  logic         clr,
   input  logic         adv,
   input  logic [W-1:0] lim_m,
   input  logic [W-1:0] lim_t,
   input  logic [W-1:0] lim_n,
   output logic [W-1:0] m_nxt,
   output logic [W-1:0] t_nxt,
   output logic [W-1:0] n_nxt,
   output logic         last
);

   logic [W-1:0] m_q, m_d, t_q, t_d, n_q, n_d;
   logic         m_wrap, t_wrap, n_wrap;

   // Wrap detection per level and the next index values.
   always_comb begin
      n_wrap = (n_q == lim_n - 1'b1);
      t_wrap = (t_q == lim_t - 1'b1);
      m_wrap = (m_q == lim_m - 1'b1);
      last   = n_wrap & t_wrap & m_wrap;
      m_d    = m_q;
      t_d    = t_q;
      n_d    = n_q;
      if (clr) begin
         m_d = '0;
         t_d = '0;
         n_d = '0;
      end else if (adv) begin
         if (!n_wrap) begin
            n_d = n_q + 1'b1;
         end else begin
            n_d = '0;
            if (!t_wrap) begin
               t_d = t_q + 1'b1;
            end else begin
               t_d = '0;
               m_d = m_wrap ? '0 : m_q + 1'b1;
            end
         end
      end
   end

   assign m_nxt = m_d;
   assign t_nxt = t_d;
   assign n_nxt = n_d;

   // Index registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         m_q <= '0;
         t_q <= '0;
         n_q <= '0;
      end else begin
         m_q <= m_d;
         t_q <= t_d;
         n_q <= n_d;
      end
   end

endmodule

// File: rtl/mac_tile_ctrl.sv
// Tile sequencer for the ARRxARR MAC array: splits an MxNxT job into tiles and issues descriptors.
// Latency: first descriptor 2 cycles after Start; Done LAT+1 cycles after the last tile is accepted.
// Backpressure: valid/ready; the registered descriptor holds steady while TileValid & !TileReady.
module mac_tile_ctrl
   import mac_pkg::*;
#(
   parameter int ARR    = DEF_ARR,
   parameter int DIM_W  = DEF_DIM_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAT    = 2*ARR+1,
   parameter int TI_W   = DIM_W,
   parameter int SH_W   = $clog2(ARR*DATA_W+1)
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       Start,
   input  logic [3*DIM_W-1:0]         MNT,
   output logic                       TileValid,
   input  logic                       TileReady,
   output logic [TI_W-1:0]            MIdx,
   output logic [TI_W-1:0]            NIdx,
   output logic [TI_W-1:0]            TIdx,
   output logic [SH_W-1:0]            shI,
   output logic [SH_W-1:0]            shW,
   output logic [$clog2(ARR+1)-1:0]   RowAct,
   output logic [$clog2(ARR+1)-1:0]   ColAct,
   output logic [2*TI_W-1:0]          ODst,
   output logic                       Acc,
   output logic                       Busy,
   output logic                       Done,
   output logic                       Err
);

   localparam int CW    = $clog2(ARR+1);
   localparam int OW    = 2*TI_W;
   localparam int CNT_W = $clog2(LAT+1);

   state_t             state_q, state_d;
   logic [DIM_W-1:0]   m_q, m_d, n_q, n_d, t_q, t_d;
   logic [TI_W-1:0]    mt_q, mt_d, nt_q, nt_d, tt_q, tt_d;
   logic               tvld_q, tvld_d, err_q, err_d;
   logic [CNT_W-1:0]   drain_q, drain_d;
   tile_desc_t         desc_q, desc_d;
   logic [TI_W-1:0]    m_nxt, t_nxt, n_nxt;
   logic               last, accept, clr;

   // Elements of this tile that fall inside the dimension (the final tile may be partial).
   function automatic logic [CW-1:0] act_cnt(input logic [DIM_W-1:0] dim, input logic [TI_W-1:0] idx);
      int unsigned rem;
      rem = 32'(dim) - 32'(idx) * 32'(ARR);
      return (rem >= 32'(ARR)) ? CW'(ARR) : CW'(rem);
   endfunction

   function automatic tile_desc_t mk_desc(input logic [TI_W-1:0] mi, input logic [TI_W-1:0] ni,
                                          input logic [TI_W-1:0] ti, input logic [DIM_W-1:0] m,
                                          input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] t,
                                          input logic [TI_W-1:0] tt);
      tile_desc_t d;
      logic [CW-1:0] kact;
      kact      = act_cnt(n, ni);
      d.m_idx   = mi;
      d.n_idx   = ni;
      d.t_idx   = ti;
      d.sh_i    = SH_W'((32'(ARR) - 32'(kact)) * 32'(DATA_W));
      d.sh_w    = d.sh_i;
      d.row_act = act_cnt(m, mi);
      d.col_act = act_cnt(t, ti);
      d.o_dst   = OW'(mi) * OW'(tt) + OW'(ti);
      d.acc     = (ni != '0);
      return d;
   endfunction

   assign accept = tvld_q & TileReady;
   assign clr    = (state_q == LOAD);

   tile_counter #(.W(TI_W)) u_cnt (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .clr   (clr),
      .adv   (accept),
      .lim_m (mt_q),
      .lim_t (tt_q),
      .lim_n (nt_q),
      .m_nxt (m_nxt),
      .t_nxt (t_nxt),
      .n_nxt (n_nxt),
      .last  (last)
   );

   // Next-state, job latching, descriptor generation and drain countdown.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      n_d     = n_q;
      t_d     = t_q;
      mt_d    = mt_q;
      nt_d    = nt_q;
      tt_d    = tt_q;
      tvld_d  = tvld_q;
      err_d   = err_q;
      drain_d = drain_q;
      desc_d  = desc_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               m_d     = MNT[3*DIM_W-1 -: DIM_W];
               n_d     = MNT[2*DIM_W-1 -: DIM_W];
               t_d     = MNT[DIM_W-1:0];
               err_d   = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            mt_d = TI_W'(ceil_div(32'(m_q), 32'(ARR)));
            nt_d = TI_W'(ceil_div(32'(n_q), 32'(ARR)));
            tt_d = TI_W'(ceil_div(32'(t_q), 32'(ARR)));
            if (m_q == '0 || n_q == '0 || t_q == '0) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               // Counter is being cleared, so the next indices are the first tile (ODst is 0).
               desc_d  = mk_desc(m_nxt, n_nxt, t_nxt, m_q, n_q, t_q, tt_q);
               tvld_d  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               if (last) begin
                  tvld_d  = 1'b0;
                  drain_d = CNT_W'(LAT-1);
                  state_d = DRAIN;
               end else begin
                  desc_d = mk_desc(m_nxt, n_nxt, t_nxt, m_q, n_q, t_q, tt_q);
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) state_d = FIN;
            else               drain_d = drain_q - 1'b1;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         m_q     <= '0;
         n_q     <= '0;
         t_q     <= '0;
         mt_q    <= '0;
         nt_q    <= '0;
         tt_q    <= '0;
         tvld_q  <= 1'b0;
         err_q   <= 1'b0;
         drain_q <= '0;
         desc_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         n_q     <= n_d;
         t_q     <= t_d;
         mt_q    <= mt_d;
         nt_q    <= nt_d;
         tt_q    <= tt_d;
         tvld_q  <= tvld_d;
         err_q   <= err_d;
         drain_q <= drain_d;
         desc_q  <= desc_d;
      end
   end

   assign TileValid = tvld_q;
   assign MIdx      = desc_q.m_idx;
   assign NIdx      = desc_q.n_idx;
   assign TIdx      = desc_q.t_idx;
   assign shI       = desc_q.sh_i;
   assign shW       = desc_q.sh_w;
   assign RowAct    = desc_q.row_act;
   assign ColAct    = desc_q.col_act;
   assign ODst      = desc_q.o_dst;
   assign Acc       = desc_q.acc;
   assign Busy      = (state_q == LOAD) || (state_q == ISSUE) || (state_q == DRAIN);
   assign Done      = (state_q == FIN);
   assign Err       = err_q;

endmodule

// File: tb/tb_mac_tile_ctrl.sv
// Self-checking bench for mac_tile_ctrl: table of jobs plus random stalls/jobs against a tile-list model.
// Latency: n/a.
// Backpressure: drives TileReady either constantly high or randomly.
module tb_mac_tile_ctrl;

   localparam int ARR    = 4;
   localparam int DIM_W  = 5;
   localparam int DATA_W = 8;
   localparam int LAT    = 2*ARR+1;
   localparam int BUDGET = 700;

   logic                CLK, RSTN, Start, TileValid, TileReady;
   logic [3*DIM_W-1:0]  MNT;
   logic [4:0]          MIdx, NIdx, TIdx;
   logic [5:0]          shI, shW;
   logic [2:0]          RowAct, ColAct;
   logic [9:0]          ODst;
   logic                Acc, Busy, Done, Err;

   int n_chk  = 0;
   int n_fail = 0;

   mac_tile_ctrl dut (
      .CLK(CLK), .RSTN(RSTN), .Start(Start), .MNT(MNT),
      .TileValid(TileValid), .TileReady(TileReady),
      .MIdx(MIdx), .NIdx(NIdx), .TIdx(TIdx), .shI(shI), .shW(shW),
      .RowAct(RowAct), .ColAct(ColAct), .ODst(ODst), .Acc(Acc),
      .Busy(Busy), .Done(Done), .Err(Err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int m, n, t;
      int exp_tiles;
      bit exp_err;
      int exp_done;   // cycles from Start to Done with TileReady held high
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] dut_pack();
      return 64'({MIdx, NIdx, TIdx, shI, shW, RowAct, ColAct, ODst, Acc});
   endfunction

   function automatic int min_arr(input int v);
      return (v > ARR) ? ARR : v;
   endfunction

   // Expected descriptor of tile (mi, ni, ti) straight from the tiling arithmetic.
   function automatic logic [63:0] exp_pack(input int m, input int n, input int t,
                                            input int mi, input int ni, input int ti, input int tt);
      int k, sh, row, col, od;
      k   = min_arr(n - ni*ARR);
      sh  = (ARR - k) * DATA_W;
      row = min_arr(m - mi*ARR);
      col = min_arr(t - ti*ARR);
      od  = mi*tt + ti;
      return 64'({5'(mi), 5'(ni), 5'(ti), 6'(sh), 6'(sh), 3'(row), 3'(col), 10'(od), 1'(ni != 0)});
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_job(input int m, input int n, input int t, input bit rnd_rdy,
                          input int extra_start, output int tiles, output int done_cyc,
                          output bit err_seen);
      logic [63:0] expq[$];
      logic [63:0] prev_pack, cur;
      bit          prev_stall, rdy;
      int          mt, nt, tt, last_acc;
      mt = (m + ARR - 1) / ARR;
      nt = (n + ARR - 1) / ARR;
      tt = (t + ARR - 1) / ARR;
      if (m > 0 && n > 0 && t > 0)
         for (int mi = 0; mi < mt; mi++)
            for (int ti = 0; ti < tt; ti++)
               for (int ni = 0; ni < nt; ni++)
                  expq.push_back(exp_pack(m, n, t, mi, ni, ti, tt));
      tiles      = 0;
      done_cyc   = -1;
      err_seen   = 1'b0;
      last_acc   = -1;
      prev_stall = 1'b0;
      prev_pack  = '0;
      MNT        = {5'(m), 5'(n), 5'(t)};
      Start      = 1'b1;
      for (int cyc = 1; cyc <= BUDGET && done_cyc < 0; cyc++) begin
         tick();
         Start = (cyc == extra_start);
         if (cyc == extra_start) MNT = {5'd4, 5'd4, 5'd4};
         if (cyc == 1) chk("busy_in_load", Busy, 1);
         cur = dut_pack();
         if (prev_stall) begin
            chk("valid_held_in_stall", TileValid, 1);
            chk("desc_stable_in_stall", cur, prev_pack);
         end
         if (Done) begin
            done_cyc = cyc;
            err_seen = Err;
            chk("busy_low_at_done", Busy, 0);
         end
         rdy       = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         TileReady = rdy;
         if (TileValid && rdy) begin
            if (tiles == 0 && !rnd_rdy) chk("first_tile_cycle", cyc, 2);
            tiles++;
            last_acc = cyc;
            if (expq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL extra_tile: got tile 0x%0h, expected none", cur);
            end else begin
               chk("tile_desc", cur, expq.pop_front());
            end
         end
         prev_stall = TileValid && !rdy;
         prev_pack  = cur;
      end
      Start     = 1'b0;
      TileReady = 1'b0;
      if (done_cyc < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: got no Done in %0d cycles, expected Done", BUDGET);
      end
      chk("model_tiles_left", expq.size(), 0);
      if (last_acc >= 0 && done_cyc >= 0) chk("done_after_last", done_cyc - last_acc, LAT + 1);
      tick();
      chk("done_one_cycle", Done, 0);
   endtask

   initial begin
      vec_t vecs[9];
      int   tiles, dc, seen;
      bit   err;
      int   rm, rn, rt;

      vecs[0] = '{4, 4, 4, 1, 1'b0, 12};
      vecs[1] = '{8, 8, 8, 8, 1'b0, 19};
      vecs[2] = '{5, 6, 3, 4, 1'b0, 15};
      vecs[3] = '{0, 4, 4, 0, 1'b1, 2};
      vecs[4] = '{4, 0, 4, 0, 1'b1, 2};
      vecs[5] = '{4, 4, 0, 0, 1'b1, 2};
      vecs[6] = '{1, 1, 1, 1, 1'b0, 12};
      vecs[7] = '{9, 2, 13, 12, 1'b0, 23};
      vecs[8] = '{31, 31, 31, 512, 1'b0, 523};

      RSTN = 1'b0; Start = 1'b0; TileReady = 1'b0; MNT = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_desc", dut_pack(), 0);
      chk("reset_valid", TileValid, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_err", Err, 0);
      RSTN = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_job(vecs[i].m, vecs[i].n, vecs[i].t, 1'b0, -1, tiles, dc, err);
         chk($sformatf("v%0d_tiles", i), tiles, vecs[i].exp_tiles);
         chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
         chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
      end

      // Start while the job is issuing must be ignored.
      run_job(8, 8, 8, 1'b0, 5, tiles, dc, err);
      chk("ign_start_tiles", tiles, 8);
      chk("ign_start_done", dc, 19);

      // Random stalls on 8x8x8.
      for (int r = 0; r < 3; r++) begin
         run_job(8, 8, 8, 1'b1, -1, tiles, dc, err);
         chk("stall_tiles", tiles, 8);
         chk("stall_err", err, 0);
      end

      // Random jobs with random stalls.
      for (int r = 0; r < 8; r++) begin
         rm = $urandom_range(1, 12);
         rn = $urandom_range(1, 12);
         rt = $urandom_range(1, 12);
         run_job(rm, rn, rt, 1'b1, -1, tiles, dc, err);
         chk("rand_tiles", tiles, ((rm+3)/4) * ((rn+3)/4) * ((rt+3)/4));
         chk("rand_err", err, 0);
      end

      // Reset in the middle of ISSUE aborts without Done.
      MNT = {5'd8, 5'd8, 5'd8};
      Start = 1'b1;
      TileReady = 1'b1;
      tick();
      Start = 1'b0;
      repeat (4) tick();
      RSTN = 1'b0;
      #1;
      chk("abort_desc", dut_pack(), 0);
      chk("abort_valid", TileValid, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      tick();
      RSTN = 1'b1;
      TileReady = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (Done || TileValid) seen++;
      end
      chk("abort_no_activity", seen, 0);
      run_job(4, 4, 4, 1'b0, -1, tiles, dc, err);
      chk("post_abort_tiles", tiles, 1);
      chk("post_abort_done", dc, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_tile_ctrl.md
# mac_tile_ctrl

Parametrised tile-sequencing controller for the ARR×ARR MAC array. It computes O[M×T] = W[M×N]·I[N×T] for dimensions up to 2^DIM_W−1 by splitting the job into ARR-sized tiles. For each tile it issues the operand pointers, the partial-width operand shift amounts, the output-memory destination and the accumulate/store mode over a valid/ready handshake. It then waits for the array pipeline to drain and signals completion.

## Interface
- ARR, 4: MAC array edge (rows = cols = ARR), ≥2
- DIM_W, 5: width of each of M, N, T
- DATA_W, 8: operand element width in bits; shift unit
- LAT, 2*ARR+1: array pipeline drain cycles after the last tile
- TI_W, DIM_W: tile-index width
- SH_W, $clog2(ARR*DATA_W+1): shift-amount width
- CLK  in  1  clock
- RSTN  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle job request, honoured only in IDLE
- MNT  in  3*DIM_W  {M, N, T}, M in MSBs; sampled on accepted Start
- TileValid  out  1  tile descriptor valid
- TileReady  in  1  array datapath accepts the descriptor
- MIdx, NIdx, TIdx  out  TI_W each  tile indices (W row-tile, reduction tile, I col-tile)
- shI, shW  out  SH_W  right-shift of packed I/W operand word = (ARR−kact)*DATA_W
- RowAct, ColAct  out  $clog2(ARR+1)  active output rows / cols in this tile
- ODst  out  2*TI_W  output tile address = MIdx*tt + TIdx
- Acc  out  1  1: add into ODst; 0: overwrite ODst
- Busy  out  1  job in progress (LOAD through DRAIN)
- Done  out  1  one-cycle pulse at job end
- Err  out  1  valid with Done; job rejected

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, FIN.
- IDLE: on Start, latch M, N, T and go to LOAD. Start in any other state is ignored.
- LOAD: compute mt=ceil(M/ARR), nt=ceil(N/ARR), tt=ceil(T/ARR) and clear the indices.
  - If any dimension is 0, set Err and go to FIN.
  - Otherwise go to ISSUE.
- ISSUE: the loop order is MIdx outer, TIdx middle, NIdx inner (the reduction runs innermost, so accumulation into one ODst is contiguous).
  - kact = min(ARR, N−NIdx*ARR); shI = shW = (ARR−kact)*DATA_W.
  - RowAct = min(ARR, M−MIdx*ARR); ColAct = min(ARR, T−TIdx*ARR).
  - Acc = (NIdx≠0).
  - On TileValid&TileReady: advance NIdx. When NIdx wraps at nt, advance TIdx. When TIdx wraps at tt, advance MIdx.
  - On acceptance of the last tile (all three indices at max), go to DRAIN.
- DRAIN: the counter loads LAT−1 and counts to 0, then the FSM goes to FIN.
- FIN: Done=1 for one cycle, then IDLE. Err is cleared on the next accepted Start.
- Arithmetic is unsigned. tt*MIdx+TIdx fits in 2*TI_W with no wrap.
- Reset values: state IDLE, all indices 0, TileValid 0, Done 0, Err 0, Busy 0, Acc 0, shI=shW=0, RowAct=ColAct=0, ODst 0.
- Reset mid-job aborts immediately. No Done is emitted.

## Timing
- Start sampled at edge k → LOAD during k+1 → TileValid high from edge k+2.
- The descriptor is registered. All tile fields are stable while TileValid & !TileReady, and TileValid never drops before acceptance.
- With TileReady held at 1, tiles issue back-to-back at one per cycle with no bubbles. Total tiles = mt*nt*tt.
- Done fires LAT+1 cycles after the cycle in which the last tile is accepted.
- An error job produces Done+Err 2 cycles after Start, with no TileValid.
- Busy=1 from LOAD through DRAIN. It is 0 in FIN and IDLE.

## Structure
- Package mac_pkg holds: the state enum (IDLE, LOAD, ISSUE, DRAIN, FIN), a ceil_div function, and the tile descriptor struct {MIdx, NIdx, TIdx, shI, shW, RowAct, ColAct, ODst, Acc}.
- One sub-module, tile_counter: a 3-level nested wrap counter with an advance enable, per-level limits and a last flag. The FSM and the descriptor-register logic stay in mac_tile_ctrl.

## Test plan
- ARR=4, MNT={4,4,4}, TileReady=1 → exactly one tile: Idx 0/0/0, shI=shW=0, RowAct=ColAct=4, Acc=0, ODst=0; Done 2+1+LAT cycles after Start.
- MNT={8,8,8} → 8 tiles in order (m,t,n) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…; Acc pattern 0,1,0,1…; ODst 0,0,1,1,2,2,3,3.
- MNT={5,6,3} → tiles with NIdx=1 have shI=shW=16; MIdx=1 tiles have RowAct=1; all tiles have ColAct=3.
- Random TileReady stalls on MNT={8,8,8} → descriptor fields unchanged during stalls, no tile lost or duplicated, 8 handshakes total.
- MNT={0,4,4} → no TileValid, Done=Err=1 at Start+2. A Start during an active job is ignored. RSTN asserted mid-ISSUE → all outputs at reset values, and the next Start runs cleanly.
